ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have a parameter NOP_INSN, default 32'h0000_0013, giving the instruction driven when no valid fetch is presented.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: the decode stage cannot accept this cycle.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: a branch or jump redirect is requested.
REQ-007 The block SHALL have port redirect_pc, input, `width: the redirect target.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction-memory request valid.
REQ-009 The block SHALL have port imem_addr, output, `width: the request address.
REQ-010 The block SHALL have port imem_gnt, input, 1 bit: the request is accepted in this cycle.
REQ-011 The block SHALL have port imem_rvalid, input, 1 bit: response data is valid.
REQ-012 The block SHALL have port imem_rdata, input, `width: the response instruction.
REQ-013 The block SHALL have port if_now_pc, output, `width: the PC of the presented instruction.
REQ-014 The block SHALL have port if_pc_plus_4, output, `width: if_now_pc + 4.
REQ-015 The block SHALL have port if_instruction, output, `width: the presented instruction.
REQ-016 The block SHALL have port if_valid, output, 1 bit: the if_* outputs hold a real fetched instruction.

Function
REQ-017 The block SHALL implement a state machine with states REQ (imem_req high), WAIT (one request granted, response pending) and HOLD (output valid, stalled, no request).
REQ-018 The block SHALL keep at most one request outstanding; imem_req SHALL be low in WAIT and HOLD.
REQ-019 In REQ, imem_addr SHALL equal fetch_pc, and imem_addr SHALL stay stable while imem_req is high without imem_gnt.
REQ-020 In REQ with imem_gnt, the block SHALL go to WAIT, latch req_pc = fetch_pc, and set fetch_pc = fetch_pc + 4.
REQ-021 In WAIT with imem_rvalid and no discard pending, the block SHALL register if_instruction = imem_rdata, if_now_pc = req_pc, if_pc_plus_4 = req_pc + 4 and if_valid = 1, so outputs change one cycle after imem_rvalid.
REQ-022 On that response, if stall is low the block SHALL go to REQ; if stall is high it SHALL go to HOLD.
REQ-023 In HOLD, the block SHALL hold all if_* outputs and return to REQ in the first cycle stall is low.
REQ-024 When stall is low and no new response is captured, the block SHALL set if_valid = 0 and if_instruction = NOP_INSN (if_now_pc and if_pc_plus_4 are don't-care, held).
REQ-025 While stall is high, the block SHALL hold all if_* outputs unchanged, including if_valid = 0 or NOP.
REQ-026 Redirect SHALL have priority over stall and over all other events.
REQ-027 On redirect_valid, the block SHALL set fetch_pc = redirect_pc and clear if_valid (if_instruction = NOP_INSN) next cycle.
REQ-028 On redirect in REQ or HOLD, the next state SHALL be REQ.
REQ-029 On redirect in REQ with imem_gnt in the same cycle, the granted request SHALL be treated as outstanding-and-discarded.
REQ-030 On redirect in WAIT, the block SHALL set discard and stay in WAIT; the next imem_rvalid SHALL be dropped without updating if_*, then the block goes to REQ fetching redirect_pc.
REQ-031 On redirect in WAIT coincident with imem_rvalid, that response SHALL be dropped, discard SHALL not be set, and the next state SHALL be REQ.
REQ-032 A new redirect while discard is pending SHALL overwrite fetch_pc and keep discard (one drop only).
REQ-033 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-034 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-035 With sys_rst high at a clock edge, the block SHALL set state = REQ, fetch_pc = RESET_PC, discard = 0, if_valid = 0, if_instruction = NOP_INSN, if_now_pc = RESET_PC and if_pc_plus_4 = RESET_PC + 4.
REQ-036 Reset SHALL override stall and redirect, abandon any outstanding request, and ignore any later stale rvalid until a new grant.
REQ-037 imem_req SHALL be high in the first cycle after reset is released.

Verification
REQ-038 Reset release with imem_gnt = 1 and rvalid a cycle later -> fetches 0x0, 0x4, 0x8; if_valid pulses; if_now_pc and if_pc_plus_4 correct.
REQ-039 imem_gnt low for 3 cycles -> imem_req stays high and imem_addr stays constant at 0x8.
REQ-040 Response arrives with stall high for 2 cycles -> HOLD; outputs frozen; no imem_req; resumes on stall low.
REQ-041 Redirect to 0x100 while in WAIT -> next rvalid (data 0xDEADBEEF) dropped; next request address is 0x100; if_valid stays 0 until 0x100 returns.
REQ-042 Redirect coincident with rvalid, and redirect coincident with stall -> the response is dropped and fetch of redirect_pc starts next cycle.
REQ-043 Start with fetch_pc = 0xFFFF_FFFC -> if_pc_plus_4 = 0x0 and the next imem_addr = 0x0; a reset asserted in WAIT with a later stray rvalid -> if_valid stays 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// presents fetched instructions to decode, honouring stall and redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_now_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_discard;
    logic [31:0] r_now_pc;
    logic [31:0] r_pc_plus_4;
    logic [31:0] r_instruction;
    logic        r_valid;

    logic w_in_req;
    logic w_in_wait;
    logic w_grant;
    logic w_resp;
    logic w_capture;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_grant   = w_in_req & imem_gnt;
    // Responses only count while a request is outstanding.
    assign w_resp    = w_in_wait & imem_rvalid;
    assign w_capture = w_resp & ~r_discard & ~redirect_valid;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; redirect dominates everything except reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_REQ: begin
                if (imem_gnt) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid || r_discard || !stall) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !stall) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = w_in_req;
        imem_addr = r_fetch_pc;
    end

    // Fetch-side datapath: next PC, outstanding request PC and discard flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_grant) begin
                r_req_pc <= r_fetch_pc;
            end
            // A redirect leaves a single stale response in flight unless it
            // is being consumed this very cycle.
            if (redirect_valid && (w_grant || (w_in_wait && !imem_rvalid))) begin
                r_discard <= 1'b1;
            end else if (w_resp) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Decode-side output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSN;
            r_now_pc      <= RESET_PC;
            r_pc_plus_4   <= RESET_PC + 32'd4;
        end else if (redirect_valid) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSN;
        end else if (w_capture) begin
            r_valid       <= 1'b1;
            r_instruction <= imem_rdata;
            r_now_pc      <= r_req_pc;
            r_pc_plus_4   <= r_req_pc + 32'd4;
        end else if (!stall) begin
            r_valid       <= 1'b0;
            r_instruction <= NOP_INSN;
        end
    end

    assign if_valid       = r_valid;
    assign if_instruction = r_instruction;
    assign if_now_pc      = r_now_pc;
    assign if_pc_plus_4   = r_pc_plus_4;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: fetch flow, grant backpressure, stall/hold,
// redirect/discard cases, PC wrap and reset with a stray response.
module tb_ifu_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_now_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_now_pc      (if_now_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant one request, then return its response one cycle later.
    task automatic fetch(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] insn,
                           input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        chk({tag, ".insn"}, if_instruction, insn);
        chk({tag, ".pc"}, if_now_pc, pc);
        chk({tag, ".pc4"}, if_pc_plus_4, pc + 32'd4);
        $display("[TB] %s: valid=%0b insn=%h pc=%h pc4=%h req=%0b addr=%h",
                 tag, if_valid, if_instruction, if_now_pc, if_pc_plus_4, imem_req, imem_addr);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        sys_rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk_out("reset", 1'b0, NOP, 32'h0);
        chk_req("reset", 1'b1, 32'h0);

        // Basic sequential fetches
        sys_rst = 1'b0;
        fetch(32'hA000_0000);
        chk_out("fetch0", 1'b1, 32'hA000_0000, 32'h0);
        chk_req("fetch0", 1'b1, 32'h4);
        imem_gnt = 1'b1;
        tick();
        chk("fetch1.pulse", {31'd0, if_valid}, 32'd0);
        chk_req("fetch1.wait", 1'b0, 32'h0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004;
        tick();
        imem_rvalid = 1'b0;
        chk_out("fetch1", 1'b1, 32'hA000_0004, 32'h4);

        // Grant withheld: request and address stay put
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_req("nogrant", 1'b1, 32'h8);
        end
        chk("nogrant.valid", {31'd0, if_valid}, 32'd0);
        fetch(32'hA000_0008);
        chk_out("fetch2", 1'b1, 32'hA000_0008, 32'h8);

        // Response under stall enters HOLD
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hD100_000C;
        tick();
        imem_rvalid = 1'b0;
        chk_out("hold1", 1'b1, 32'hD100_000C, 32'hC);
        chk_req("hold1", 1'b0, 32'h0);
        tick();
        chk_out("hold2", 1'b1, 32'hD100_000C, 32'hC);
        chk_req("hold2", 1'b0, 32'h0);
        stall = 1'b0;
        tick();
        chk("resume.valid", {31'd0, if_valid}, 32'd0);
        chk("resume.insn", if_instruction, NOP);
        chk_req("resume", 1'b1, 32'h10);

        // Redirect in WAIT: next response is dropped
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk_req("rdw.wait", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("rdw.valid", {31'd0, if_valid}, 32'd0);
        chk("rdw.insn", if_instruction, NOP);
        chk_req("rdw", 1'b1, 32'h100);
        fetch(32'h0000_1111);
        chk_out("rdw.fetch", 1'b1, 32'h0000_1111, 32'h100);

        // Redirect coincident with rvalid
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        chk("rdv.valid", {31'd0, if_valid}, 32'd0);
        chk("rdv.insn", if_instruction, NOP);
        chk_req("rdv", 1'b1, 32'h200);
        fetch(32'h0000_2222);
        chk_out("rdv.fetch", 1'b1, 32'h0000_2222, 32'h200);

        // Redirect coincident with stall and rvalid
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002; stall = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        chk("rds.valid", {31'd0, if_valid}, 32'd0);
        chk("rds.insn", if_instruction, NOP);
        chk_req("rds", 1'b1, 32'h300);
        fetch(32'h0000_3333);
        chk_out("rds.fetch", 1'b1, 32'h0000_3333, 32'h300);

        // Redirect in REQ with a grant in the same cycle
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b0;
        chk_req("rdg.wait", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
        tick();
        imem_rvalid = 1'b0;
        chk("rdg.valid", {31'd0, if_valid}, 32'd0);
        chk_req("rdg", 1'b1, 32'h400);
        fetch(32'h0000_4444);
        chk_out("rdg.fetch", 1'b1, 32'h0000_4444, 32'h400);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk_req("wrap.req", 1'b1, 32'hFFFF_FFFC);
        fetch(32'h0000_5555);
        chk_out("wrap", 1'b1, 32'h0000_5555, 32'hFFFF_FFFC);
        chk("wrap.pc4", if_pc_plus_4, 32'h0);
        chk_req("wrap.next", 1'b1, 32'h0);

        // Reset while waiting, then a stray response
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0004;
        tick();
        imem_rvalid = 1'b0;
        chk_out("rststray", 1'b0, NOP, 32'h0);
        chk_req("rststray", 1'b1, 32'h0);
        tick();
        chk("rststray2.valid", {31'd0, if_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
